// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read. Pointers carry an extra
// wrap bit so full and empty can be told apart when the index bits match.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr, do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = CW'(wr_ptr - rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte port into a FIFO, LSB-first serializer
// driving the RsTx pin. Back-to-back frames run with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [UART_DATA_BITS-1:0]       tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            RsTx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    tx_state_t                 state;
    logic [BW-1:0]             baud_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] head;
    logic                      fifo_full, fifo_empty;
    logic                      push, pop, bit_last;

    assign tx_ready = reset && !fifo_full;
    assign push     = tx_valid && tx_ready;
    assign bit_last = (baud_cnt == BW'(CLKS_PER_BIT-1));
    // Pop from IDLE immediately, or at the last stop-bit cycle to chain frames.
    assign pop      = !fifo_empty && ((state == IDLE) || (state == STOP && bit_last));
    assign busy     = (state != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            RsTx     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    RsTx     <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= head;
                        state <= START;
                        RsTx  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        RsTx     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'(UART_DATA_BITS-1)) begin
                            state <= STOP;
                            RsTx  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            RsTx    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= head;
                            state <= START;
                            RsTx  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    RsTx  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: bytes are queued on accept and checked bit-by-bit as
// frames appear on RsTx, plus latency, gap, full-FIFO and reset cases.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int FRAME = 10*CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, RsTx, busy;
    logic [CW-1:0] fifo_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    bit         in_frame = 1'b0;
    int         fidx = 0;
    logic [9:0] fpat = '1;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .RsTx       (RsTx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Line decoder: a start bit pops the next expected byte, every cycle of the frame is checked.
    always @(negedge clk) begin
        if (!reset) begin
            in_frame = 1'b0;
            exp_q.delete();
        end else if (in_frame) begin
            chk("rstx_bit", RsTx, fpat[fidx/CPB]);
            fidx++;
            if (fidx == FRAME) in_frame = 1'b0;
        end else if (RsTx === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("spurious_start", RsTx, 1'b1);
            end else begin
                fpat = {1'b1, exp_q.pop_front(), 1'b0};
                start_q.push_back(cyc);
                in_frame = 1'b1;
                fidx = 1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] b, output int acc);
        tx_data  = b;
        tx_valid = 1'b1;
        acc      = -1;
        for (int i = 0; i < 300 && acc < 0; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                exp_q.push_back(b);
                acc = cyc + 1;
            end
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        if (acc < 0) chk("accept_timeout", tx_ready, 1'b1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !in_frame && !busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a5, a6, s0, s1, st;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", tx_ready, 1'b0);
        chk("rst_rstx", RsTx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fifo_count, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // idle line
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            chk("idle_rstx", RsTx, 1'b1);
            chk("idle_busy", busy, 1'b0);
            chk("idle_ready", tx_ready, 1'b1);
            chk("idle_count", fifo_count, 0);
        end
        @(posedge clk); #1;

        // single byte: latency and busy fall
        s0 = start_q.size();
        send(8'h55, a);
        while (cyc < a + FRAME) @(negedge clk);
        chk("busy_last", busy, 1'b1);
        @(negedge clk);
        chk("busy_fall", busy, 1'b0);
        wait_idle();
        chk("single_frames", start_q.size(), s0 + 1);
        if (start_q.size() > s0) chk("latency", start_q[s0], a + 1);

        // back-to-back frames
        s0 = start_q.size();
        send(8'hA5, a);
        send(8'h3C, a);
        wait_idle();
        chk("b2b_frames", start_q.size(), s0 + 2);
        if (start_q.size() > s0 + 1) chk("b2b_gap", start_q[s0+1] - start_q[s0], FRAME);

        // full FIFO with valid held
        s0 = start_q.size();
        send(8'h01, a1);
        send(8'h02, a);
        send(8'h03, a);
        send(8'h04, a);
        send(8'h05, a5);
        tx_data  = 8'h06;
        tx_valid = 1'b1;
        @(negedge clk);
        chk("full_count", fifo_count, DEPTH);
        chk("full_ready", tx_ready, 1'b0);
        chk("full_busy", busy, 1'b1);
        @(posedge clk); #1;
        send(8'h06, a6);
        send(8'h07, a);
        send(8'h08, a);
        chk("five_accepted", a5, a1 + 4);
        if (start_q.size() > s0) chk("acc6_after_pop", a6, start_q[s0] + FRAME + 1);
        wait_idle();
        chk("full_frames", start_q.size(), s0 + 8);

        // reset during bit 3 of the first frame
        s0 = start_q.size();
        send(8'h11, a);
        send(8'h22, a);
        send(8'h33, a);
        for (int i = 0; i < 50 && start_q.size() <= s0; i++) @(negedge clk);
        chk("mid_started", start_q.size(), s0 + 1);
        if (start_q.size() > s0) begin
            st = start_q[s0];
            while (cyc < st + 17) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            chk("mid_rstx", RsTx, 1'b1);
            chk("mid_count", fifo_count, 0);
            chk("mid_busy", busy, 1'b0);
            chk("mid_ready", tx_ready, 1'b0);
            @(posedge clk); #1;
            reset = 1'b1;
            s1 = start_q.size();
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                chk("post_rst_rstx", RsTx, 1'b1);
            end
            chk("post_rst_frames", start_q.size(), s1);
            chk("post_rst_busy", busy, 1'b0);
            @(posedge clk); #1;
        end

        // loopback-style byte
        s0 = start_q.size();
        send(8'h41, a);
        wait_idle();
        chk("loop_frames", start_q.size(), s0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter. The outbound counterpart to the existing RsRx receive path in top.
- Drives the board RsTx pin, so the CPU or a debug block can return bytes to the host.
- Bytes enter through a valid/ready write port, wait in a small FIFO, and are serialized LSB-first with one start bit and one stop bit.
- Sits beside the UART receiver in top. It is fed later by a memory-mapped store path.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud, truncated); must be >= 2.
- FIFO_DEPTH, 16, byte entries in the input FIFO; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low; reset==0 at a rising edge clears all state.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept; a byte is accepted on any edge where tx_valid && tx_ready.
- RsTx  output  1  serial line, idle high; registered.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  entries currently held in the FIFO.

Behaviour:
- Reset (reset==0 at an edge):
  - RsTx=1, busy=0, fifo_count=0.
  - FSM to IDLE; FIFO pointers, baud counter and bit index cleared.
  - tx_ready is forced 0 while reset==0.
  - Reset mid-frame abandons the frame: RsTx is high from the next edge and queued bytes are discarded.
- tx_ready = !fifo_full, combinational from FIFO state only (not from a same-cycle pop).
  - A write while full is ignored with no side effects.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: RsTx=1. If FIFO non-empty, pop the head into an 8-bit shift register and go to START at the same edge.
  - START: RsTx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: RsTx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit 7 go to STOP.
  - STOP: RsTx=1 for CLKS_PER_BIT cycles. At the last cycle, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Timing:
  - Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state/bit change.
  - Every bit is exactly CLKS_PER_BIT cycles; a frame is exactly 10*CLKS_PER_BIT cycles.
  - Latency: byte accepted at edge N into an empty FIFO with the FSM in IDLE → pop at edge N+1 → RsTx low from edge N+1.
- Capacity: the in-flight byte lives in the shift register, so up to FIFO_DEPTH+1 bytes are outstanding.
- Simultaneous push and pop: both take effect; fifo_count is unchanged.
- fifo_count updates at the edge after an accept or pop.
- busy = (state != IDLE) || (fifo_count != 0).
- Pointer wrap-around is natural modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer MSB.
- No parity, no break generation, no flow control.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE/START/DATA/STOP);
  - UART_DATA_BITS=8;
  - DEFAULT_CLKS_PER_BIT=868.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - ports clk, reset, wr_en, wr_data, rd_en, rd_data, full, empty, count;
  - same active-low synchronous reset;
  - rd_data is combinational from the head entry.
- uart_tx instantiates sync_fifo and contains the FSM, baud counter and shift register.

Test Plan:
1. Idle check: release reset, no writes for 200 cycles → RsTx=1, busy=0, tx_ready=1, fifo_count=0 throughout.
2. Single byte, CLKS_PER_BIT=4: write 0x55 at edge N → from N+1, RsTx holds 0,1,0,1,0,1,0,1,0,1 for 4 cycles each (40 cycles), then 1. busy falls at edge N+41.
3. Back-to-back, CLKS_PER_BIT=4: write 0xA5 then 0x3C on consecutive cycles → second start bit begins exactly 40 cycles after the first. Data bits are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0, with no idle cycle between frames.
4. Full FIFO, FIFO_DEPTH=4: hold tx_valid with bytes 0x01..0x08 → exactly 5 accepted (0x01..0x05). tx_ready=0 while fifo_count=4; 0x06 is accepted only after 0x01's frame pops 0x02. All bytes are sent in order.
5. Reset mid-frame: queue 0x11, 0x22, 0x33, then pull reset low during 0x11's bit 3 → RsTx=1 next edge, fifo_count=0, busy=0. After release, nothing further is transmitted.
6. Loopback in top: tie RsTx to RsRx and write 0x41 → the existing receiver captures 0x41 within 10*CLKS_PER_BIT+receiver latency cycles.
